// File: rtl/kpn_arith_node.sv
// rtl/kpn_arith_node.sv - two-input streaming arithmetic KPN node with per-channel token FIFOs
// Pairs tokens from channels A and B in arrival order and emits one registered result per fire.

module kpn_token_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end
endmodule

module kpn_arith_node #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] last_result,
    output logic             show_result
);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             a_full, a_empty, b_full, b_empty;
    logic [WIDTH-1:0] a_head, b_head;
    logic             fire;
    logic [WIDTH-1:0] diff, sum, calc;
    logic             sub_ovf, add_ovf, calc_ovf;

    // Ready depends only on stored occupancy, so a full FIFO never passes a token through.
    assign a_ready = !a_full;
    assign b_ready = !b_full;
    assign fire    = !a_empty && !b_empty && (!res_valid || res_ready);

    kpn_token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (a_valid && a_ready),
        .push_data (a_data),
        .pop       (fire),
        .pop_data  (a_head),
        .full      (a_full),
        .empty     (a_empty)
    );

    kpn_token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (b_valid && b_ready),
        .push_data (b_data),
        .pop       (fire),
        .pop_data  (b_head),
        .full      (b_full),
        .empty     (b_empty)
    );

    always_comb begin
        diff     = a_head - b_head;
        sum      = a_head + b_head;
        sub_ovf  = (a_head[WIDTH-1] != b_head[WIDTH-1]) && (diff[WIDTH-1] != a_head[WIDTH-1]);
        add_ovf  = (a_head[WIDTH-1] == b_head[WIDTH-1]) && (sum[WIDTH-1] != a_head[WIDTH-1]);
        calc     = diff;
        calc_ovf = 1'b0;
        unique case (op)
            2'b00: begin
                calc     = diff;
                calc_ovf = sub_ovf;
            end
            2'b01: begin
                calc     = sum;
                calc_ovf = add_ovf;
            end
            2'b10: begin
                // On overflow the true result has the sign of the minuend.
                calc     = sub_ovf ? (a_head[WIDTH-1] ? SMIN : SMAX) : diff;
                calc_ovf = sub_ovf;
            end
            default: begin
                calc     = (a_head >= b_head) ? diff : (b_head - a_head);
                calc_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_data    <= '0;
            res_ovf     <= 1'b0;
            res_valid   <= 1'b0;
            last_result <= '0;
            show_result <= 1'b0;
        end else if (flush) begin
            res_data    <= '0;
            res_ovf     <= 1'b0;
            res_valid   <= 1'b0;
            last_result <= '0;
            show_result <= 1'b0;
        end else if (fire) begin
            res_data    <= calc;
            res_ovf     <= calc_ovf;
            res_valid   <= 1'b1;
            last_result <= calc;
            show_result <= 1'b1;
        end else if (res_ready) begin
            res_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_kpn_arith_node.sv
// tb/tb_kpn_arith_node.sv - directed vector bench for kpn_arith_node
`timescale 1ns/1ps

module tb_kpn_arith_node;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] last_result;
    logic             show_result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             ovf;
    } vec_t;

    vec_t vecs [12];
    logic [WIDTH-1:0] exp_q [$];

    kpn_arith_node #(.WIDTH(WIDTH), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .a_data      (a_data),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .b_data      (b_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .op          (op),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .last_result (last_result),
        .show_result (show_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        check({tag, "_res_data"}, 32'(res_data), 32'(0));
        check({tag, "_res_ovf"}, 32'(res_ovf), 32'(0));
        check({tag, "_last_result"}, 32'(last_result), 32'(0));
        check({tag, "_show_result"}, 32'(show_result), 32'(0));
        check({tag, "_a_ready"}, 32'(a_ready), 32'(1));
        check({tag, "_b_ready"}, 32'(b_ready), 32'(1));
    endtask

    initial begin
        vecs[0]  = '{2'b00, 16'h0005, 16'h0007, 16'hFFFE, 1'b0};
        vecs[1]  = '{2'b00, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
        vecs[2]  = '{2'b00, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1};
        vecs[3]  = '{2'b01, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
        vecs[4]  = '{2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
        vecs[5]  = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[6]  = '{2'b10, 16'h8000, 16'h0001, 16'h8000, 1'b1};
        vecs[7]  = '{2'b10, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1};
        vecs[8]  = '{2'b10, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
        vecs[9]  = '{2'b11, 16'h0003, 16'h0009, 16'h0006, 1'b0};
        vecs[10] = '{2'b11, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
        vecs[11] = '{2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0};

        // Power-on reset
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        reset_n = 1'b1;
        tick();

        // Asynchronous reset with three A tokens queued and a held result
        res_ready = 1'b0;
        op = 2'b01;
        for (int i = 0; i < 4; i++) begin
            a_data = 16'h0100 + 16'(i);
            a_valid = 1'b1;
            b_data = 16'h0001;
            b_valid = (i == 0);
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("pre_reset_res_valid", 32'(res_valid), 32'(1));
        check("pre_reset_res_data", 32'(res_data), 32'h0101);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        res_ready = 1'b1;
        tick();
        b_data = 16'h0002;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        tick();
        tick();
        check("lost_tokens_no_result", 32'(res_valid), 32'(0));
        op = 2'b00;
        a_data = 16'h0009;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        check("post_reset_pair_valid", 32'(res_valid), 32'(1));
        check("post_reset_pair_data", 32'(res_data), 32'h0007);
        tick();

        // Table-driven single pairs, with push-to-valid latency
        for (int i = 0; i < 12; i++) begin
            op = vecs[i].op;
            a_data = vecs[i].a;
            b_data = vecs[i].b;
            a_valid = 1'b1;
            b_valid = 1'b1;
            tick();
            a_valid = 1'b0;
            b_valid = 1'b0;
            check($sformatf("v%0d_not_yet_valid", i), 32'(res_valid), 32'(0));
            tick();
            check($sformatf("v%0d_valid", i), 32'(res_valid), 32'(1));
            check($sformatf("v%0d_data", i), 32'(res_data), 32'(vecs[i].res));
            check($sformatf("v%0d_ovf", i), 32'(res_ovf), 32'(vecs[i].ovf));
            check($sformatf("v%0d_last", i), 32'(last_result), 32'(vecs[i].res));
            check($sformatf("v%0d_show", i), 32'(show_result), 32'(1));
            tick();
            check($sformatf("v%0d_drained", i), 32'(res_valid), 32'(0));
        end

        // Backpressure: five tokens per channel fill output stage plus both FIFOs
        res_ready = 1'b0;
        op = 2'b01;
        exp_q.delete();
        for (int i = 1; i <= 5; i++) begin
            a_data = 16'h0101 * 16'(i);
            b_data = 16'h0010 * 16'(i);
            exp_q.push_back((16'h0101 * 16'(i)) + (16'h0010 * 16'(i)));
            a_valid = 1'b1;
            b_valid = 1'b1;
            tick();
        end
        check("bp_a_ready_full", 32'(a_ready), 32'(0));
        check("bp_b_ready_full", 32'(b_ready), 32'(0));
        check("bp_held_valid", 32'(res_valid), 32'(1));
        check("bp_held_data", 32'(res_data), 32'h0111);
        a_data = 16'hDEAD;
        b_data = 16'hBEEF;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("bp_still_held", 32'(res_data), 32'h0111);
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_r%0d_valid", k), 32'(res_valid), 32'(1));
            check($sformatf("bp_r%0d_data", k), 32'(res_data), 32'(exp_q[k]));
            tick();
            if (k == 0) begin
                check("bp_a_ready_after_pop", 32'(a_ready), 32'(1));
            end
        end
        check("bp_no_extra_result", 32'(res_valid), 32'(0));

        // Flush with a held result and a queued A token
        res_ready = 1'b0;
        op = 2'b11;
        a_data = 16'h0003;
        b_data = 16'h0009;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        a_data = 16'h0044;
        b_valid = 1'b0;
        tick();
        a_valid = 1'b0;
        check("fl_pre_data", 32'(res_data), 32'h0006);
        check("fl_pre_show", 32'(show_result), 32'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_reset_outputs("flush");
        res_ready = 1'b1;
        b_data = 16'h0001;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        tick();
        tick();
        check("fl_a_token_dropped", 32'(res_valid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
